snf_rxdat: RTL
==============

// Module: snf_rxdat
// PURPOSE
//  - CHI-E link-layer RX DAT channel receiver for the SN-F. Counterpart of the SN-F TX DAT path.
//  - Grants L-credits to the link partner on rxdatlcrdv and accepts rxdatflit into a credit-sized FIFO.
//  - Delivers the flits to snf_data_buffer over a valid/ready handshake.
//  - Absorbs DataLCrdReturn flits and flags flits that arrive without a credit.
// PARAMETERS
//  - FLIT_WIDTH     `CHIE_DAT_FLIT_WIDTH  width of one DAT flit.
//  - CRD_MAX        4   FIFO depth and max outstanding L-credits. Legal range 1..15.
//  - CRD_CNT_WIDTH  4   counter width. Must satisfy 2**CRD_CNT_WIDTH > CRD_MAX.
// PORTS
//  - clk                 in   1           single clock; all state is on the rising edge.
//  - rst                 in   1           asynchronous, active-low reset (asserted when rst==0).
//  - rx_link_active      in   1           from snf_link; 1 = RX link in RUN, credits may be granted.
//  - rxdatflitv          in   1           flit valid from the link.
//  - rxdatflit           in   FLIT_WIDTH  flit payload.
//  - rxdatflitpend       in   1           early flit indication; ignored.
//  - rxdatlcrdv          out  1           registered; one L-credit granted per high cycle.
//  - rxdat_dbf_valid_s1  out  1           FIFO head valid toward snf_data_buffer.
//  - rxdat_dbf_flit_s1   out  FLIT_WIDTH  FIFO head flit; all zeros when the FIFO is empty.
//  - dbf_rxdat_rdy_s1    in   1           data buffer accepts the head this cycle.
//  - rxdat_crd_idle      out  1           1 when no credits are outstanding (link deactivation may complete).
//  - rxdat_crd_err       out  1           sticky; set when a flit arrives with zero outstanding credits.
// BEHAVIOUR
//  - Reset values: all outputs 0 except rxdat_crd_idle=1. Pointers, occupancy and crd_out_q are 0.
//  - crd_out_q counts credits granted and not yet consumed by a flit.
//  - occ_q counts FIFO entries held.
//  - Credit grant:
//    - Next-cycle rxdatlcrdv=1 iff rx_link_active && (occ_q + crd_out_q + rxdatlcrdv_q < CRD_MAX).
//    - The sum uses CRD_CNT_WIDTH+1 bits, so it cannot wrap.
//    - At most one grant per cycle; a grant increments crd_out_q on its high cycle.
//  - Flit receive: on rxdatflitv with crd_out_q != 0, crd_out_q decrements.
//    - If opcode (`CHIE_DAT_FLIT_OPCODE_RANGE) == `CHIE_DATLCRDRETURN, the flit is dropped, not written.
//    - Otherwise the flit is written at wr_ptr, and wr_ptr wraps at CRD_MAX-1 -> 0.
//  - A grant and a flit in the same cycle leave crd_out_q unchanged.
//  - Protocol error: rxdatflitv with crd_out_q==0 sets rxdat_crd_err.
//    - The flit is discarded and no counter changes.
//    - The error clears only on reset.
//  - Delivery:
//    - rxdat_dbf_valid_s1 = (occ_q != 0).
//    - Pop when valid && dbf_rxdat_rdy_s1; rd_ptr wraps like wr_ptr.
//    - Latency: a flit captured at edge N is presented in cycle N+1, with no bypass.
//    - Head must hold stable while valid && !rdy.
//  - Simultaneous push and pop: occ_q is unchanged. A push into a full FIFO cannot occur (credit invariant).
//  - Invariant: occ_q + crd_out_q <= CRD_MAX at every edge.
//  - rxdat_crd_idle = (crd_out_q==0) && !rxdatlcrdv.
//  - rx_link_active deasserted mid-operation:
//    - Grants stop the next cycle.
//    - Credits already out are consumed by data or DataLCrdReturn flits.
//    - The FIFO keeps draining.
//  - Reset mid-operation: everything clears immediately.
//    - Buffered flits are lost.
//    - rxdatlcrdv drops asynchronously.
// STRUCTURE
//  - Shared defines go in snf_defines.v / snf_param.v:
//    - SNF_LL_RXDAT_CRD_MAX and SNF_LL_RXDAT_CRD_CNT_WIDTH.
//    - `CHIE_DATLCRDRETURN, if not already in chie_defines.v.
//  - One sub-module: snf_ll_rx_fifo, a parameterised width/depth register FIFO.
//    - Ports: push, pop, head, occupancy.
//    - Reused later for RXREQ/RXRSP.
//  - Credit logic stays in snf_rxdat.
// TESTING
//  1. Reset release, rx_link_active=1, no flits.
//     -> rxdatlcrdv high for exactly 4 consecutive cycles, then crd_out_q=4 and rxdat_crd_idle=0.
//  2. 4 data flits back-to-back with rdy=0.
//     -> occ=4, no further credits. Then rdy=1 -> 4 pops in order, 4 new credits, each granted 1 cycle after its pop.
//  3. Flit and credit grant in the same cycle.
//     -> crd_out_q unchanged and flit presented next cycle. Also: flit at edge N, rdy=1 -> valid in cycle N+1 only.
//  4. Deassert rx_link_active with 4 credits out, then send 4 DataLCrdReturn (opcode 0).
//     -> FIFO stays empty, crd_out_q 4->0, rxdat_crd_idle=1, no grants.
//  5. Inject rxdatflitv while crd_out_q=0.
//     -> rxdat_crd_err=1 and stays 1, flit not delivered, counters unchanged.
//  6. Assert rst=0 with occ=2 and crd_out=2.
//     -> all outputs 0 immediately, idle=1. After release, credits are re-granted from 0 up to 4.

Source files
------------

// File: rtl/snf_rxdat_pkg.sv
// Shared constants and types for the SN-F link-layer RX DAT receiver.
package snf_rxdat_pkg;

    // Default DAT flit width and credit sizing for the RX DAT channel.
    localparam int SNF_DAT_FLIT_WIDTH         = 64;
    localparam int SNF_LL_RXDAT_CRD_MAX       = 4;
    localparam int SNF_LL_RXDAT_CRD_CNT_WIDTH = 4;

    // Location of the opcode field inside a DAT flit.
    localparam int CHIE_DAT_OPCODE_LSB   = 49;
    localparam int CHIE_DAT_OPCODE_WIDTH = 4;

    typedef logic [CHIE_DAT_OPCODE_WIDTH-1:0] dat_opcode_t;

    // DataLCrdReturn only hands an L-credit back; it never carries data.
    localparam dat_opcode_t CHIE_DATLCRDRETURN = 4'h0;
    localparam dat_opcode_t CHIE_DAT_COMPDATA  = 4'h4;

    // Extract the opcode field from a default-width DAT flit.
    function automatic dat_opcode_t dat_opcode(input logic [SNF_DAT_FLIT_WIDTH-1:0] flit);
        return flit[CHIE_DAT_OPCODE_LSB +: CHIE_DAT_OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/snf_rxdat_if.sv
// RX DAT link and data-buffer handshake bundle.
// Handshake: the link side is credit based (one flit per granted L-credit,
// rxdatlcrdv high for one cycle per credit). The data-buffer side is strict
// valid/ready: a head transfers on a cycle where valid && rdy; while valid is
// high and rdy is low the head flit holds stable and valid stays asserted.
interface snf_rxdat_if;

    logic                                         rxdatflitv;
    logic [snf_rxdat_pkg::SNF_DAT_FLIT_WIDTH-1:0] rxdatflit;
    logic                                         rxdatflitpend;
    logic                                         rxdatlcrdv;
    logic                                         rxdat_dbf_valid_s1;
    logic [snf_rxdat_pkg::SNF_DAT_FLIT_WIDTH-1:0] rxdat_dbf_flit_s1;
    logic                                         dbf_rxdat_rdy_s1;

    // Receiver side (snf_rxdat).
    modport slave (
        input  rxdatflitv, rxdatflit, rxdatflitpend, dbf_rxdat_rdy_s1,
        output rxdatlcrdv, rxdat_dbf_valid_s1, rxdat_dbf_flit_s1
    );

    // Link partner plus data buffer side.
    modport master (
        output rxdatflitv, rxdatflit, rxdatflitpend, dbf_rxdat_rdy_s1,
        input  rxdatlcrdv, rxdat_dbf_valid_s1, rxdat_dbf_flit_s1
    );

endinterface

// File: rtl/snf_ll_rx_fifo.sv
// Parameterised register FIFO for link-layer RX channels. The head reads
// zero when empty; no write-to-read bypass.
module snf_ll_rx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             do_pop;

    assign do_pop    = pop && (occ_q != '0);
    assign head      = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign occupancy = occ_q;

    // Next-state: write at wr_ptr, read at rd_ptr, both wrapping at DEPTH-1.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, do_pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset drops all buffered entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/snf_rxdat.sv
// SN-F CHI-E RX DAT link receiver: L-credit grant, credit-sized FIFO,
// DataLCrdReturn absorption and sticky no-credit error flag.
module snf_rxdat
    import snf_rxdat_pkg::*;
#(
    parameter int FLIT_WIDTH    = SNF_DAT_FLIT_WIDTH,
    parameter int CRD_MAX       = SNF_LL_RXDAT_CRD_MAX,
    parameter int CRD_CNT_WIDTH = SNF_LL_RXDAT_CRD_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_link_active,
    snf_rxdat_if.slave               rx,
    output logic                     rxdat_crd_idle,
    output logic                     rxdat_crd_err,
    output logic [CRD_CNT_WIDTH-1:0] crd_out_dbg,
    output logic [CRD_CNT_WIDTH-1:0] occ_dbg
);

    localparam int SUM_W = CRD_CNT_WIDTH + 1;

    logic                     lcrdv_q, lcrdv_d;
    logic [CRD_CNT_WIDTH-1:0] crd_out_q, crd_out_d;
    logic                     err_q, err_d;
    logic [CRD_CNT_WIDTH-1:0] occ;
    logic [FLIT_WIDTH-1:0]    head;
    logic [SUM_W-1:0]         credit_sum;
    logic                     flit_ok;
    logic                     is_lcrd_return;
    logic                     push;
    logic                     pop;
    logic                     unused_flitpend;

    // Early flit indication carries no information this receiver needs.
    assign unused_flitpend = rx.rxdatflitpend;

    assign flit_ok        = rx.rxdatflitv && (crd_out_q != '0);
    assign is_lcrd_return = (rx.rxdatflit[CHIE_DAT_OPCODE_LSB +: CHIE_DAT_OPCODE_WIDTH]
                             == CHIE_DATLCRDRETURN);
    assign push           = flit_ok && !is_lcrd_return;
    assign pop            = (occ != '0) && rx.dbf_rxdat_rdy_s1;

    // Credit accounting: grant while buffered + outstanding + in-flight grant
    // stays below the FIFO depth; a grant and a consumed flit cancel out.
    always_comb begin
        credit_sum = {1'b0, occ} + {1'b0, crd_out_q} + SUM_W'(lcrdv_q);
        lcrdv_d    = rx_link_active && (credit_sum < SUM_W'(CRD_MAX));
        case ({lcrdv_q, flit_ok})
            2'b10:   crd_out_d = crd_out_q + CRD_CNT_WIDTH'(1);
            2'b01:   crd_out_d = crd_out_q - CRD_CNT_WIDTH'(1);
            default: crd_out_d = crd_out_q;
        endcase
        err_d = err_q || (rx.rxdatflitv && (crd_out_q == '0));
    end

    // Credit and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcrdv_q   <= 1'b0;
            crd_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            lcrdv_q   <= lcrdv_d;
            crd_out_q <= crd_out_d;
            err_q     <= err_d;
        end
    end

    snf_ll_rx_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (CRD_MAX),
        .CNT_W (CRD_CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .din       (rx.rxdatflit),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

    assign rx.rxdatlcrdv         = lcrdv_q;
    assign rx.rxdat_dbf_valid_s1 = (occ != '0);
    assign rx.rxdat_dbf_flit_s1  = head;
    assign rxdat_crd_idle        = (crd_out_q == '0) && !lcrdv_q;
    assign rxdat_crd_err         = err_q;
    assign crd_out_dbg           = crd_out_q;
    assign occ_dbg               = occ;

endmodule
